// File: rtl/audio_synth_pkg.sv
// Shared widths, wave encodings and envelope states for the tone generator.
// Also holds the elaboration-time quarter-wave sine table builder.
package audio_synth_pkg;

   localparam int DUTY_W   = 10;
   localparam int DUTY_MID = 512;
   localparam int ENV_MAX  = 1023;

   localparam logic [1:0] WAVE_SQUARE = 2'b00;
   localparam logic [1:0] WAVE_SAW    = 2'b01;
   localparam logic [1:0] WAVE_TRI    = 2'b10;
   localparam logic [1:0] WAVE_SINE   = 2'b11;

   typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

   // Constant-only: Taylor series so the table needs no math library at elaboration.
   function automatic logic [255:0][8:0] build_sine_rom();
      logic [255:0][8:0] rom;
      real x, term, s;
      rom = '0;
      for (int i = 0; i < 256; i++) begin
         x    = 3.14159265358979 * real'(i) / 512.0;
         term = x;
         s    = x;
         for (int n = 1; n < 6; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            s    = s + term;
         end
         rom[i] = 9'($rtoi(511.0 * s + 0.5));
      end
      return rom;
   endfunction

endpackage

// File: rtl/tone_envelope_fsm.sv
// Envelope state machine: strobe priority, attack/sustain/release stepping of env.
// env and state update on the clock edge that ends a tick cycle.
module tone_envelope_fsm
   import audio_synth_pkg::*;
#(
   parameter int ATTACK_STEP  = 4,
   parameter int RELEASE_STEP = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              note_on,
   input  logic              note_off,
   output logic [DUTY_W-1:0] env,
   output logic              active
);

   env_state_t        state, state_next;
   logic [DUTY_W-1:0] env_next;
   logic [DUTY_W:0]   env_up;

   assign env_up = {1'b0, env} + (DUTY_W+1)'(ATTACK_STEP);
   assign active = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         env   <= '0;
      end else begin
         state <= state_next;
         env   <= env_next;
      end
   end

   // Strobes pick the new state first; a coincident tick then steps env under that state.
   always_comb begin
      state_next = state;
      env_next   = env;
      if (note_on)
         state_next = ATTACK;
      else if (note_off && (state == ATTACK || state == SUSTAIN))
         state_next = RELEASE;

      if (tick) begin
         case (state_next)
            ATTACK: begin
               if (env_up >= (DUTY_W+1)'(ENV_MAX)) begin
                  env_next   = DUTY_W'(ENV_MAX);
                  state_next = SUSTAIN;
               end else begin
                  env_next = env_up[DUTY_W-1:0];
               end
            end
            RELEASE: begin
               if (env <= DUTY_W'(RELEASE_STEP)) begin
                  env_next   = '0;
                  state_next = IDLE;
               end else begin
                  env_next = env - DUTY_W'(RELEASE_STEP);
               end
            end
            default: env_next = env;
         endcase
      end
   end

endmodule

// File: rtl/tone_envelope_gen.sv
// Phase-accumulator tone source scaled by an ASR envelope; duty_cycle lags a tick by 2 cycles.
// Optional SINE_LUT_EN adds a quarter-wave sine table for wave_sel=11 (otherwise DC at midscale).
module tone_envelope_gen
   import audio_synth_pkg::*;
#(
   parameter int SYS_FREQ_MHZ   = 31,
   parameter int SAMPLE_RATE_HZ = 31000,
   parameter int PHASE_BITS     = 24,
   parameter int ATTACK_STEP    = 4,
   parameter int RELEASE_STEP   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  note_on,
   input  logic                  note_off,
   input  logic [PHASE_BITS-1:0] phase_inc,
   input  logic [1:0]            wave_sel,
   output logic [DUTY_W-1:0]     duty_cycle,
   output logic                  audio_enable,
   output logic                  sample_tick
);

   localparam int TICK_DIV = SYS_FREQ_MHZ * 1000000 / SAMPLE_RATE_HZ;
   localparam int CNT_W    = $clog2(TICK_DIV);

   logic [CNT_W-1:0]      tick_cnt;
   logic [PHASE_BITS-1:0] phase, phase_inc_q;
   logic [1:0]            wave_q;
   logic [DUTY_W-1:0]     env, raw, duty_next;
   logic                  active;
   logic signed [10:0]    s;
   logic signed [20:0]    prod;

   assign sample_tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt     <= '0;
         phase        <= '0;
         phase_inc_q  <= '0;
         wave_q       <= WAVE_SQUARE;
         duty_cycle   <= DUTY_W'(DUTY_MID);
         audio_enable <= 1'b0;
      end else begin
         tick_cnt <= sample_tick ? '0 : tick_cnt + 1'b1;
         if (note_on) begin
            phase_inc_q <= phase_inc;
            wave_q      <= wave_sel;
         end
         // A fresh note restarts at phase 0; a retrigger keeps the running phase.
         if (note_on && !active)
            phase <= '0;
         else if (sample_tick && active)
            phase <= phase + phase_inc_q;
         duty_cycle   <= duty_next;
         audio_enable <= active;
      end
   end

   tone_envelope_fsm #(
      .ATTACK_STEP  (ATTACK_STEP),
      .RELEASE_STEP (RELEASE_STEP)
   ) u_fsm (
      .clk      (clk),
      .reset    (reset),
      .tick     (sample_tick),
      .note_on  (note_on),
      .note_off (note_off),
      .env      (env),
      .active   (active)
   );

`ifdef SINE_LUT_EN
   localparam logic [255:0][8:0] SINE_ROM = build_sine_rom();
   logic [7:0] sine_idx;
   logic [8:0] sine_q;

   always_comb begin
      sine_idx = phase[PHASE_BITS-3 -: 8];
      if (phase[PHASE_BITS-2])
         sine_idx = ~sine_idx;
      sine_q = SINE_ROM[sine_idx];
   end
`endif

   always_comb begin
      raw = DUTY_W'(DUTY_MID);
      case (wave_q)
         WAVE_SQUARE: raw = phase[PHASE_BITS-1] ? DUTY_W'(ENV_MAX) : '0;
         WAVE_SAW:    raw = phase[PHASE_BITS-1 -: 10];
         WAVE_TRI:    raw = phase[PHASE_BITS-1] ? ~{phase[PHASE_BITS-2 -: 9], 1'b0}
                                                :  {phase[PHASE_BITS-2 -: 9], 1'b0};
`ifdef SINE_LUT_EN
         WAVE_SINE:   raw = phase[PHASE_BITS-1] ? DUTY_W'(DUTY_MID) - {1'b0, sine_q}
                                                : DUTY_W'(DUTY_MID) + {1'b0, sine_q};
`endif
         default:     raw = DUTY_W'(DUTY_MID);
      endcase
   end

   // Floor of the arithmetic shift keeps the result within 0..1022.
   assign s         = $signed({1'b0, raw}) - 11'sd512;
   assign prod      = 21'(s) * 21'($signed({1'b0, env}));
   assign duty_next = DUTY_W'((prod >>> 10) + 21'sd512);

endmodule

// File: tb/tb_tone_envelope_gen.sv
// Directed bench: dut_a uses 1023-sized envelope steps, dut_b the 4/2 defaults; both share stimulus.
module tb_tone_envelope_gen;
   import audio_synth_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        note_on = 1'b0;
   logic        note_off = 1'b0;
   logic [23:0] phase_inc = '0;
   logic [1:0]  wave_sel = 2'b00;
   logic [9:0]  duty_a, duty_b;
   logic        ae_a, ae_b, tick_a, tick_b;

   int checks = 0;
   int errors = 0;
   int exp_sq[6] = '{0, 1022, 1022, 0, 0, 1022};

   always #5 clk = ~clk;

   tone_envelope_gen #(
      .SYS_FREQ_MHZ(1), .SAMPLE_RATE_HZ(100000), .PHASE_BITS(24),
      .ATTACK_STEP(1023), .RELEASE_STEP(1023)
   ) dut_a (
      .clk(clk), .reset(reset), .note_on(note_on), .note_off(note_off),
      .phase_inc(phase_inc), .wave_sel(wave_sel),
      .duty_cycle(duty_a), .audio_enable(ae_a), .sample_tick(tick_a)
   );

   tone_envelope_gen #(
      .SYS_FREQ_MHZ(1), .SAMPLE_RATE_HZ(100000), .PHASE_BITS(24),
      .ATTACK_STEP(4), .RELEASE_STEP(2)
   ) dut_b (
      .clk(clk), .reset(reset), .note_on(note_on), .note_off(note_off),
      .phase_inc(phase_inc), .wave_sel(wave_sel),
      .duty_cycle(duty_b), .audio_enable(ae_b), .sample_tick(tick_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns just after the edge that closes the tick cycle.
   task automatic wait_tick();
      int n = 0;
      while (!tick_a && n < 20) begin
         step();
         n++;
      end
      check("tick_seen", 32'(tick_a), 32'd1);
      step();
   endtask

   initial begin
      // 1. reset and idle
      #12;
      check("rst_duty", 32'(duty_a), 32'd512);
      check("rst_ae", 32'(ae_a), 32'd0);
      check("rst_tick", 32'(tick_a), 32'd0);
      step();
      reset = 1'b0;
      check("tick_k0", 32'(tick_a), 32'd0);
      for (int k = 1; k <= 30; k++) begin
         step();
         check("tick_pattern", 32'(tick_a), (k % 10 == 9) ? 32'd1 : 32'd0);
      end
      check("tick_b_match", 32'(tick_b), 32'(tick_a));
      check("idle_phase", 32'(dut_a.phase), 32'd0);
      check("idle_duty", 32'(duty_a), 32'd512);

      // 2. square, full attack in one tick
      wave_sel  = WAVE_SQUARE;
      phase_inc = 24'h400000;
      note_on   = 1'b1;
      step();
      note_on = 1'b0;
      check("on_state", 32'(dut_a.u_fsm.state), 32'(ATTACK));
      check("on_ae_lag", 32'(ae_a), 32'd0);
      step();
      check("on_ae", 32'(ae_a), 32'd1);
      for (int i = 0; i < 6; i++) begin
         wait_tick();
         check("sq_state", 32'(dut_a.u_fsm.state), 32'(SUSTAIN));
         check("sq_env", 32'(dut_a.u_fsm.env), 32'd1023);
         step();
         check("sq_duty", 32'(duty_a), 32'(exp_sq[i]));
      end

      // 3. release in one tick
      note_off = 1'b1;
      step();
      note_off = 1'b0;
      check("rel_state", 32'(dut_a.u_fsm.state), 32'(RELEASE));
      wait_tick();
      check("rel_idle", 32'(dut_a.u_fsm.state), 32'(IDLE));
      check("rel_env", 32'(dut_a.u_fsm.env), 32'd0);
      check("rel_ae_lag", 32'(ae_a), 32'd1);
      step();
      check("rel_ae_off", 32'(ae_a), 32'd0);
      check("rel_duty", 32'(duty_a), 32'd512);

      // 4. attack ramp on dut_b, saw at phase 0 (raw=0)
      reset = 1'b1;
      step();
      reset     = 1'b0;
      wave_sel  = WAVE_SAW;
      phase_inc = '0;
      note_on   = 1'b1;
      step();
      note_on = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         wait_tick();
         check("ramp_env", 32'(dut_b.u_fsm.env), (k < 256) ? 32'(4 * k) : 32'd1023);
         if (k == 255) check("ramp_state255", 32'(dut_b.u_fsm.state), 32'(ATTACK));
         if (k == 256) check("ramp_state256", 32'(dut_b.u_fsm.state), 32'(SUSTAIN));
         if (k == 1) begin
            step();
            check("ramp_duty1", 32'(duty_b), 32'd510);
         end
      end
      step();
      check("ramp_duty_full", 32'(duty_b), 32'd0);

      // 5. strobe priority
      note_on  = 1'b1;
      note_off = 1'b1;
      step();
      note_on  = 1'b0;
      note_off = 1'b0;
      check("both_state", 32'(dut_b.u_fsm.state), 32'(ATTACK));
      check("both_env", 32'(dut_b.u_fsm.env), 32'd1023);
      check("both_state_a", 32'(dut_a.u_fsm.state), 32'(ATTACK));
      wait_tick();
      check("both_sustain", 32'(dut_b.u_fsm.state), 32'(SUSTAIN));
      check("both_env_hold", 32'(dut_b.u_fsm.env), 32'd1023);
      note_off = 1'b1;
      step();
      note_off = 1'b0;
      check("off_a_rel", 32'(dut_a.u_fsm.state), 32'(RELEASE));
      wait_tick();
      check("off_a_idle", 32'(dut_a.u_fsm.state), 32'(IDLE));
      check("off_b_env", 32'(dut_b.u_fsm.env), 32'd1021);
      step();
      step();
      note_off = 1'b1;
      step();
      note_off = 1'b0;
      check("idle_off_state", 32'(dut_a.u_fsm.state), 32'(IDLE));
      check("idle_off_env", 32'(dut_a.u_fsm.env), 32'd0);
      check("idle_off_ae", 32'(ae_a), 32'd0);
      check("idle_off_duty", 32'(duty_a), 32'd512);
      check("rel_off_ignored", 32'(dut_b.u_fsm.state), 32'(RELEASE));

      // 6. async reset mid-release at env=600
      reset = 1'b1;
      step();
      reset   = 1'b0;
      note_on = 1'b1;
      step();
      note_on = 1'b0;
      for (int k = 1; k <= 150; k++) wait_tick();
      check("env600", 32'(dut_b.u_fsm.env), 32'd600);
      check("env600_state", 32'(dut_b.u_fsm.state), 32'(ATTACK));
      step();
      check("env600_duty", 32'(duty_b), 32'd212);
      note_off = 1'b1;
      step();
      note_off = 1'b0;
      check("env600_rel", 32'(dut_b.u_fsm.state), 32'(RELEASE));
      check("env600_rel_env", 32'(dut_b.u_fsm.env), 32'd600);
      #3;
      reset = 1'b1;
      #1;
      check("arst_duty", 32'(duty_b), 32'd512);
      check("arst_ae", 32'(ae_b), 32'd0);
      check("arst_state", 32'(dut_b.u_fsm.state), 32'(IDLE));
      check("arst_env", 32'(dut_b.u_fsm.env), 32'd0);
      check("arst_tick", 32'(tick_b), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
